// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and helpers for the multi-port memory controller
// Contents:
//   arb_mode_e  : arbitration policy (ARB_FIXED: port 0 highest, ARB_RR: round-robin)
//   port_id_w() : bits needed to hold a port index, never less than 1
package mem_ctrl_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   function automatic int port_id_w(input int num_ports);
      return (num_ports <= 1) ? 1 : $clog2(num_ports);
   endfunction

endpackage

// File: rtl/mem_ctrl_mp_if.sv
// rtl/mem_ctrl_mp_if.sv - requester-side bus bundle for mem_ctrl_mp
// Signals (per port p, slices of width AW/DATA_WIDTH/BW at p*width):
//   ren/raddr     -> read request and address      rready      <- read grant
//   rdata         <- shared read data              rdata_valid <- per-port read data valid
//   wen/waddr     -> write request and address     wready      <- write grant
//   wdata/wbe     -> write data and byte enables
// Modports: master = requesters, slave = controller.
interface mem_ctrl_mp_if #(
   parameter int NUM_PORTS  = 2,
   parameter int AW         = 5,
   parameter int DATA_WIDTH = 32,
   parameter int BW         = DATA_WIDTH / 8
);

   logic [NUM_PORTS-1:0]            ren;
   logic [NUM_PORTS*AW-1:0]         raddr;
   logic [NUM_PORTS-1:0]            rready;
   logic [DATA_WIDTH-1:0]           rdata;
   logic [NUM_PORTS-1:0]            rdata_valid;
   logic [NUM_PORTS-1:0]            wen;
   logic [NUM_PORTS*AW-1:0]         waddr;
   logic [NUM_PORTS*DATA_WIDTH-1:0] wdata;
   logic [NUM_PORTS*BW-1:0]         wbe;
   logic [NUM_PORTS-1:0]            wready;

   modport master (
      output ren, raddr, wen, waddr, wdata, wbe,
      input  rready, rdata, rdata_valid, wready
   );

   modport slave (
      input  ren, raddr, wen, waddr, wdata, wbe,
      output rready, rdata, rdata_valid, wready
   );

endinterface

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - request arbiter, fixed priority or round-robin
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-port request
//   gnt        : combinational one-hot grant, zero when nothing requests
//   gnt_id     : index of the granted port (valid when gnt is non-zero)
module mem_arb
   import mem_ctrl_pkg::*;
#(
   parameter int        NUM_PORTS = 2,
   parameter arb_mode_e ARB_MODE  = ARB_FIXED,
   localparam int       ID_W      = port_id_w(NUM_PORTS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_PORTS-1:0] req,
   output logic [NUM_PORTS-1:0] gnt,
   output logic [ID_W-1:0]      gnt_id
);

   logic [ID_W-1:0] last_q;
   logic            found;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      if (ARB_MODE == ARB_FIXED) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i] && !found) begin
               gnt[i] = 1'b1;
               gnt_id = ID_W'(i);
               found  = 1'b1;
            end
         end
      end else begin
         // Ports above the last winner get first look, then the search wraps to port 0.
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i] && !found && (i > int'(last_q))) begin
               gnt[i] = 1'b1;
               gnt_id = ID_W'(i);
               found  = 1'b1;
            end
         end
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i] && !found && (i <= int'(last_q))) begin
               gnt[i] = 1'b1;
               gnt_id = ID_W'(i);
               found  = 1'b1;
            end
         end
      end
   end

   // Reset to the highest port so port 0 is the first winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= ID_W'(NUM_PORTS - 1);
      end else if (|gnt) begin
         last_q <= gnt_id;
      end
   end

endmodule

// File: rtl/mem_ctrl_mp.sv
// rtl/mem_ctrl_mp.sv - multi-port word memory with arbitrated read and write channels
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_ctrl_mp_if.slave, per-port read/write requests, grants and read return
// Reads return RD_LAT cycles after the grant; same-cycle read/write to one address reads first.
module mem_ctrl_mp
   import mem_ctrl_pkg::*;
#(
   parameter int        NUM_PORTS  = 2,
   parameter int        MEM_DEPTH  = 32,
   parameter int        DATA_WIDTH = 32,
   parameter int        RD_LAT     = 1,
   parameter arb_mode_e ARB_MODE   = ARB_FIXED
) (
   input logic          clk,
   input logic          rst_n,
   mem_ctrl_mp_if.slave bus
);

   localparam int AW   = $clog2(MEM_DEPTH);
   localparam int BW   = DATA_WIDTH / 8;
   localparam int ID_W = port_id_w(NUM_PORTS);

   logic [NUM_PORTS-1:0]  rd_gnt, wr_gnt;
   logic [ID_W-1:0]       rd_id, wr_id;
   logic                  rd_acc, wr_acc;
   logic [AW-1:0]         rd_addr, wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [BW-1:0]         wr_be;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [RD_LAT-1:0]     pv_q;
   logic [ID_W-1:0]       pid_q [RD_LAT];
   logic [DATA_WIDTH-1:0] pd_q  [RD_LAT];

   mem_arb #(.NUM_PORTS(NUM_PORTS), .ARB_MODE(ARB_MODE)) u_rd_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (bus.ren),
      .gnt    (rd_gnt),
      .gnt_id (rd_id)
   );

   mem_arb #(.NUM_PORTS(NUM_PORTS), .ARB_MODE(ARB_MODE)) u_wr_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (bus.wen),
      .gnt    (wr_gnt),
      .gnt_id (wr_id)
   );

   assign bus.rready = rd_gnt;
   assign bus.wready = wr_gnt;
   assign rd_acc     = |rd_gnt;
   assign wr_acc     = |wr_gnt;

   always_comb begin
      rd_addr = '0;
      wr_addr = '0;
      wr_data = '0;
      wr_be   = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (rd_id == ID_W'(p)) begin
            rd_addr = bus.raddr[p*AW +: AW];
         end
         if (wr_id == ID_W'(p)) begin
            wr_addr = bus.waddr[p*AW +: AW];
            wr_data = bus.wdata[p*DATA_WIDTH +: DATA_WIDTH];
            wr_be   = bus.wbe[p*BW +: BW];
         end
      end
   end

   // Storage has no reset; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int b = 0; b < BW; b++) begin
            if (wr_be[b]) begin
               mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

   // Stage 0 samples the array at the grant edge, before the same-edge write lands (read-first).
   // A stage's data only moves when a valid word arrives, so the last stage doubles as the
   // rdata hold register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv_q <= '0;
         for (int k = 0; k < RD_LAT; k++) begin
            pid_q[k] <= '0;
            pd_q[k]  <= '0;
         end
      end else begin
         pv_q[0] <= rd_acc;
         if (rd_acc) begin
            pid_q[0] <= rd_id;
            pd_q[0]  <= mem[rd_addr];
         end
         for (int k = 1; k < RD_LAT; k++) begin
            pv_q[k] <= pv_q[k-1];
            if (pv_q[k-1]) begin
               pid_q[k] <= pid_q[k-1];
               pd_q[k]  <= pd_q[k-1];
            end
         end
      end
   end

   assign bus.rdata = pd_q[RD_LAT-1];

   always_comb begin
      bus.rdata_valid = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         bus.rdata_valid[p] = pv_q[RD_LAT-1] && (pid_q[RD_LAT-1] == ID_W'(p));
      end
   end

endmodule
